i3c_table_ram: RTL and testbench

Parametrised shared table memory for the I3C core's attached tables (DAT, DCT and future tables). It replaces direct single-client RAM instances with a single-port store that:
- arbitrates round-robin between `NumClients` requesters;
- clears itself after reset or on command;
- returns tagged read data one cycle after grant.

It sits between the controller/CSR table ports and the storage, inside the top-level wrapper.

---
 rtl/i3c_pkg.sv | 18 +
 rtl/i3c_rr_arbiter.sv | 45 ++++
 rtl/i3c_table_ram.sv | 169 ++++++++++++++++
 tb/tb_i3c_table_ram.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// i3c_pkg: shared types and default table geometries for the I3C table stores.
package i3c_pkg;

    // Table store init sequencer: CLEAR walks every entry writing zero, IDLE serves clients.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } table_ram_state_e;

    // Device Address Table geometry.
    localparam int DatDepth = 128;
    localparam int DatWidth = 64;

    // Device Characteristics Table geometry.
    localparam int DctDepth = 128;
    localparam int DctWidth = 128;

endpackage

// File: rtl/i3c_rr_arbiter.sv
// i3c_rr_arbiter: round-robin grant over NumClients requesters. The search
// starts at the client after the last one granted; the pointer only moves
// when a grant is actually issued with advance high.
module i3c_rr_arbiter #(
    parameter int NumClients = 2,
    parameter int IdxW       = (NumClients > 1) ? $clog2(NumClients) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NumClients-1:0] req,
    input  logic                  advance,
    output logic [NumClients-1:0] gnt,
    output logic [IdxW-1:0]       idx
);

    logic [IdxW-1:0] ptr;
    logic            found;
    int              cand;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NumClients; i++) begin
            cand = (int'(ptr) + i) % NumClients;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IdxW'(cand);
            end
        end
    end

    // Move the search start just past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (idx == IdxW'(NumClients - 1)) ? '0 : idx + IdxW'(1);
        end
    end

endmodule

// File: rtl/i3c_table_ram.sv
// i3c_table_ram: single-port table store shared by NumClients requesters.
// Clears itself after reset or on init_i, arbitrates round-robin, and returns
// read data one cycle after grant. Optional per-group even parity is built in
// when I3C_TABLE_RAM_PARITY_EN is defined.
module i3c_table_ram
    import i3c_pkg::*;
#(
    parameter int NumClients      = 2,
    parameter int Depth           = DatDepth,
    parameter int Width           = DatWidth,
    parameter int DataBitsPerMask = 32,
    parameter int Aw              = $clog2(Depth)
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [NumClients-1:0]                             req_i,
    input  logic [NumClients-1:0]                             write_i,
    input  logic [NumClients-1:0][Aw-1:0]                     addr_i,
    input  logic [NumClients-1:0][Width-1:0]                  wdata_i,
    input  logic [NumClients-1:0][Width/DataBitsPerMask-1:0]  wmask_i,
    input  logic                                              init_i,
`ifdef I3C_TABLE_RAM_PARITY_EN
    input  logic                                              parity_flip_i,
`endif
    output logic [NumClients-1:0]                             gnt_o,
    output logic [NumClients-1:0]                             rvalid_o,
    output logic [Width-1:0]                                  rdata_o,
    output logic [NumClients-1:0]                             rerror_o,
    output logic                                              init_busy_o
);

    localparam int Ng   = Width / DataBitsPerMask;
    localparam int Db   = DataBitsPerMask;
    localparam int IdxW = (NumClients > 1) ? $clog2(NumClients) : 1;

    table_ram_state_e state, state_next;
    logic [Aw-1:0]    clr_ptr, clr_ptr_next;
    logic             arb_en;
    logic [IdxW-1:0]  sel;
    logic [Aw-1:0]    sel_addr;
    logic             in_range;
    logic             gnt_any;
    logic             do_write;
    logic             do_read;
    logic             par_err;
    logic [Width-1:0] mem [Depth];

    // Init sequencer state and clear pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Walk the table once; init_i always restarts the walk from entry 0.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        unique case (state)
            CLEAR: begin
                if (init_i) begin
                    clr_ptr_next = '0;
                end else if (clr_ptr == Aw'(Depth - 1)) begin
                    state_next   = IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + Aw'(1);
                end
            end
            IDLE: begin
                if (init_i) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // No grants while clearing, nor in the cycle a re-clear is requested, so
    // nothing is accepted that the clear would then overwrite or orphan.
    assign arb_en      = (state == IDLE) && !init_i;
    assign init_busy_o = (state == CLEAR);

    i3c_rr_arbiter #(
        .NumClients (NumClients),
        .IdxW       (IdxW)
    ) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (req_i & {NumClients{arb_en}}),
        .advance (arb_en),
        .gnt     (gnt_o),
        .idx     (sel)
    );

    assign sel_addr = addr_i[sel];
    assign in_range = (32'(sel_addr) < 32'(Depth));
    assign gnt_any  = |gnt_o;
    assign do_write = gnt_any && write_i[sel] && in_range;
    assign do_read  = gnt_any && !write_i[sel];

    // Storage: clear walk or masked client write; never both in one cycle.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (do_write) begin
            for (int g = 0; g < Ng; g++) begin
                if (wmask_i[sel][g]) begin
                    mem[sel_addr][g*Db +: Db] <= wdata_i[sel][g*Db +: Db];
                end
            end
        end
    end

`ifdef I3C_TABLE_RAM_PARITY_EN
    logic [Ng-1:0] par_mem [Depth];

    // Per-group even parity, updated only for written groups; flip plants errors.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            par_mem[clr_ptr] <= '0;
        end else if (do_write) begin
            for (int g = 0; g < Ng; g++) begin
                if (wmask_i[sel][g]) begin
                    par_mem[sel_addr][g] <= (^wdata_i[sel][g*Db +: Db]) ^ parity_flip_i;
                end
            end
        end
    end

    // Any group whose data no longer matches its stored parity flags the read.
    always_comb begin
        par_err = 1'b0;
        if (in_range) begin
            for (int g = 0; g < Ng; g++) begin
                par_err = par_err | ((^mem[sel_addr][g*Db +: Db]) ^ par_mem[sel_addr][g]);
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // Read response register: one-cycle valid, data held between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= '0;
            rerror_o <= '0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= '0;
            rerror_o <= '0;
            if (do_read) begin
                rvalid_o <= gnt_o;
                rerror_o <= gnt_o & {NumClients{!in_range || par_err}};
                rdata_o  <= in_range ? mem[sel_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_i3c_table_ram.sv
// tb_i3c_table_ram: randomized and directed stimulus against a behavioural
// model of the table store (flat array, cyclic client search, busy countdown).
// Depth is 100 so that out-of-range addresses are representable in 7 bits.
module tb_i3c_table_ram;
    localparam int NC    = 3;
    localparam int DEPTH = 100;
    localparam int W     = 64;
    localparam int DB    = 32;
    localparam int NG    = W / DB;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b0;
    logic flip = 1'b0;
    logic [NC-1:0]         req = '0;
    logic [NC-1:0]         wr = '0;
    logic [NC-1:0][AW-1:0] addr = '0;
    logic [NC-1:0][W-1:0]  wdata = '0;
    logic [NC-1:0][NG-1:0] wmask = '0;
    logic [NC-1:0]         gnt, rvalid, rerror;
    logic [W-1:0]          rdata;
    logic                  busy;

    always #5 clk = ~clk;

    i3c_table_ram #(
        .NumClients      (NC),
        .Depth           (DEPTH),
        .Width           (W),
        .DataBitsPerMask (DB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .write_i       (wr),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .wmask_i       (wmask),
        .init_i        (init),
`ifdef I3C_TABLE_RAM_PARITY_EN
        .parity_flip_i (flip),
`endif
        .gnt_o         (gnt),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .rerror_o      (rerror),
        .init_busy_o   (busy)
    );

    // Reference model state.
    logic [W-1:0]  m_mem [DEPTH];
    logic [NG-1:0] m_bad [DEPTH];
    int            m_left  = DEPTH;
    int            m_start = 0;
    int            last_g  = -1;
    int            mode    = 0;   // 0 hold requests, 1 drop after grant, 2 random
    logic [NC-1:0] m_pv = '0;
    logic [NC-1:0] m_pe = '0;
    logic [W-1:0]  m_rd = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
            m_bad[a] = '0;
        end
    endtask

    task automatic new_req(input int c);
        req[c]   = ($urandom_range(0, 3) != 0);
        wr[c]    = 1'($urandom_range(0, 1));
        addr[c]  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, (1 << AW) - 1))
                                              : AW'($urandom_range(0, 15));
        wdata[c] = {$urandom, $urandom};
        wmask[c] = NG'($urandom_range(0, (1 << NG) - 1));
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        int g;
        int a;
        logic [NC-1:0] eg;
        g  = -1;
        eg = '0;
        @(negedge clk);
        if (!rst && !init && m_left == 0) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_start + i) % NC;
                if (g < 0 && req[c]) g = c;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", gnt, eg);
        chk("busy", busy, m_left > 0);
        chk("rvalid", rvalid, m_pv);
        chk("rerror", rerror, m_pe);
        chk("rdata", rdata, m_rd);
        @(posedge clk);
        m_pv = '0;
        m_pe = '0;
        if (rst) begin
            m_left  = DEPTH;
            m_start = 0;
            m_rd    = '0;
            clr();
        end else begin
            if (g >= 0) begin
                a = int'(addr[g]);
                m_start = (g + 1) % NC;
                if (wr[g]) begin
                    if (a < DEPTH) begin
                        for (int k = 0; k < NG; k++) begin
                            if (wmask[g][k]) begin
                                m_mem[a][k*DB +: DB] = wdata[g][k*DB +: DB];
                                m_bad[a][k] = flip;
                            end
                        end
                    end
                end else begin
                    m_pv[g] = 1'b1;
                    if (a < DEPTH) begin
                        m_rd    = m_mem[a];
                        m_pe[g] = |m_bad[a];
                    end else begin
                        m_rd    = '0;
                        m_pe[g] = 1'b1;
                    end
                end
            end
            if (init) begin
                m_left = DEPTH;
                clr();
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        last_g = g;
        #1;
        if (g >= 0) begin
            if (mode == 1) req[g] = 1'b0;
            else if (mode == 2) new_req(g);
        end
        if (mode == 2) begin
            for (int c = 0; c < NC; c++)
                if (!req[c] && $urandom_range(0, 1) == 1) new_req(c);
        end
    endtask

    // Directed single access by client c; returns data/error right after grant.
    task automatic acc(input int c, input logic w, input int a, input logic [W-1:0] d,
                       input logic [NG-1:0] m, output logic [W-1:0] rd, output logic er);
        int n;
        n        = 0;
        req[c]   = 1'b1;
        wr[c]    = w;
        addr[c]  = AW'(a);
        wdata[c] = d;
        wmask[c] = m;
        do begin
            cyc();
            n++;
        end while (last_g != c && n < 400);
        if (last_g != c) chk("acc_timeout", 0, 1);
        rd = rdata;
        er = rerror[c];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rd;
        logic         er;
        int           n;

        // Reset with every client holding a read request.
        mode = 0;
        for (int c = 0; c < NC; c++) begin
            req[c]  = 1'b1;
            wr[c]   = 1'b0;
            addr[c] = AW'(c);
        end
        repeat (3) cyc();
        rst = 1'b0;

        n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        chk("clr_len", n, DEPTH);

        // Round-robin with continuous requests: 0,1,2,0,1,2.
        cyc();
        chk("first_gnt", last_g, 0);
        for (int k = 1; k < 6; k++) begin
            cyc();
            chk("rr_order", last_g, k % NC);
            chk("clr_data", rdata, 0);
        end

        mode = 1;
        req  = '0;
        repeat (2) cyc();

        // Masked write, write-then-read, mask-0 no-op, boundary and out-of-range.
        acc(1, 1'b1, 5, 64'hAAAA_AAAA_5555_5555, 2'b01, rd, er);
        acc(1, 1'b0, 5, '0, '0, rd, er);
        chk("masked", rd, 64'h0000_0000_5555_5555);
        chk("masked_err", er, 0);
        acc(0, 1'b1, 7, 64'h1234, 2'b11, rd, er);
        acc(0, 1'b0, 7, '0, '0, rd, er);
        chk("wr_rd", rd, 64'h1234);
        acc(1, 1'b1, 7, '1, 2'b00, rd, er);
        acc(2, 1'b0, 7, '0, '0, rd, er);
        chk("mask0", rd, 64'h1234);
        acc(2, 1'b0, 110, '0, '0, rd, er);
        chk("oor_data", rd, 0);
        chk("oor_err", er, 1);
        acc(0, 1'b1, 120, '1, 2'b11, rd, er);
        acc(0, 1'b1, DEPTH - 1, 64'hFEED_0000_0000_BEEF, 2'b11, rd, er);
        acc(1, 1'b0, DEPTH - 1, '0, '0, rd, er);
        chk("last_entry", rd, 64'hFEED_0000_0000_BEEF);
        chk("last_err", er, 0);

        // Random traffic.
        mode = 2;
        for (int c = 0; c < NC; c++) new_req(c);
        repeat (1500) cyc();

        // Re-clear, restarted 10 cycles in.
        mode = 1;
        req  = '0;
        repeat (2) cyc();
        init = 1'b1;
        cyc();
        init = 1'b0;
        repeat (10) cyc();
        init = 1'b1;
        cyc();
        init = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        chk("reclr_len", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            acc(a % NC, 1'b0, a, '0, '0, rd, er);
            chk("reclr_zero", rd, 0);
        end

        // Requests pending across a clear are served afterwards.
        mode = 2;
        for (int c = 0; c < NC; c++) new_req(c);
        init = 1'b1;
        cyc();
        init = 1'b0;
        repeat (300) cyc();

`ifdef I3C_TABLE_RAM_PARITY_EN
        mode = 1;
        req  = '0;
        repeat (2) cyc();
        flip = 1'b1;
        acc(0, 1'b1, 9, 64'hDEAD_BEEF_0123_4567, 2'b11, rd, er);
        flip = 1'b0;
        acc(1, 1'b0, 9, '0, '0, rd, er);
        chk("par_err", er, 1);
        chk("par_data", rd, 64'hDEAD_BEEF_0123_4567);
        acc(2, 1'b1, 11, 64'h1111_2222_3333_4444, 2'b11, rd, er);
        acc(2, 1'b0, 11, '0, '0, rd, er);
        chk("par_clean", er, 0);
        acc(0, 1'b1, 9, 64'h0, 2'b01, rd, er);
        acc(0, 1'b0, 9, '0, '0, rd, er);
        chk("par_half", er, 1);
        acc(0, 1'b1, 9, 64'h0, 2'b10, rd, er);
        acc(0, 1'b0, 9, '0, '0, rd, er);
        chk("par_fixed", er, 0);
`endif

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
